// File: rtl/hwpe_vfpu_job_ctrl.sv
// Per-job VFPU sequencer: pairs A/B operands into the fixed-latency FP pipe, stalls it under result back-pressure.
// Latency FP_LAT from fire to result; A/B ready only together. Optional sticky flags: HWPE_VFPU_JOB_CTRL_FLAGS_EN.
module hwpe_vfpu_job_ctrl #(
   parameter int FP_LAT    = 3,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 clear_i,
   input  logic [CNT_WIDTH-1:0] transaction_size_i,
   input  logic [1:0]           operation_i,
   input  logic [1:0]           rounding_mode_i,
   input  logic                 a_valid_i,
   output logic                 a_ready_o,
   input  logic                 b_valid_i,
   output logic                 b_ready_o,
   output logic [3:0]           fpu_ctrl_o,
   output logic                 fpu_in_valid_o,
   output logic                 fpu_en_o,
   input  logic [5:0]           fpu_flags_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [5:0]           flags_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  size_q, size_d;
   logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;
   logic [FP_LAT-1:0]     vpipe_q, vpipe_d;
   logic [3:0]            ctrl_q, ctrl_d;
   logic [5:0]            flags_q, flags_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic adv, issue_ok, fire, retire;

`ifndef HWPE_VFPU_JOB_CTRL_FLAGS_EN
   logic unused_flags;
   assign unused_flags = ^fpu_flags_i;
`endif

   // A stalled result at the pipe output freezes the whole pipe, including issue.
   assign adv      = !(vpipe_q[FP_LAT-1] && !r_ready_i);
   assign issue_ok = !clear_i && (state_q == RUN) && (issue_cnt_q < size_q) && adv;
   assign fire     = issue_ok && a_valid_i && b_valid_i;
   assign retire   = vpipe_q[FP_LAT-1] && r_ready_i;

   assign a_ready_o      = issue_ok && b_valid_i;
   assign b_ready_o      = issue_ok && a_valid_i;
   assign fpu_in_valid_o = fire;
   assign fpu_en_o       = adv;
   assign r_valid_o      = vpipe_q[FP_LAT-1];
   assign fpu_ctrl_o     = ctrl_q;
   assign flags_o        = flags_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

   always_comb begin
      state_d      = state_q;
      size_d       = size_q;
      issue_cnt_d  = issue_cnt_q;
      retire_cnt_d = retire_cnt_q;
      vpipe_d      = vpipe_q;
      ctrl_d       = ctrl_q;
      flags_d      = flags_q;

      if (adv) begin
         vpipe_d[0] = fire;
         for (int i = 1; i < FP_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
         end
      end
      if (fire) begin
         issue_cnt_d = issue_cnt_q + CNT_ONE;
      end
      if (retire) begin
         retire_cnt_d = retire_cnt_q + CNT_ONE;
`ifdef HWPE_VFPU_JOB_CTRL_FLAGS_EN
         flags_d = flags_q | fpu_flags_i;
`endif
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               size_d       = transaction_size_i;
               ctrl_d       = {operation_i, rounding_mode_i};
               flags_d      = '0;
               issue_cnt_d  = '0;
               retire_cnt_d = '0;
               state_d      = (transaction_size_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (fire && (issue_cnt_q + CNT_ONE == size_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (retire && (retire_cnt_q + CNT_ONE == size_q)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d      = IDLE;
            issue_cnt_d  = '0;
            retire_cnt_d = '0;
         end
         default: state_d = IDLE;
      endcase

      // Abort drops all in-flight work but leaves the job's flags visible.
      if (clear_i) begin
         state_d      = IDLE;
         issue_cnt_d  = '0;
         retire_cnt_d = '0;
         vpipe_d      = '0;
      end

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         size_q       <= '0;
         issue_cnt_q  <= '0;
         retire_cnt_q <= '0;
         vpipe_q      <= '0;
         ctrl_q       <= '0;
         flags_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         size_q       <= size_d;
         issue_cnt_q  <= issue_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         vpipe_q      <= vpipe_d;
         ctrl_q       <= ctrl_d;
         flags_q      <= flags_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_hwpe_vfpu_job_ctrl.sv
// Directed bench for hwpe_vfpu_job_ctrl: streaming, back-pressure, operand skew, zero size, abort, flags.
module tb_hwpe_vfpu_job_ctrl;

   localparam int FP_LAT = 3;
   localparam int CW     = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i, clear_i;
   logic [CW-1:0] transaction_size_i;
   logic [1:0]    operation_i, rounding_mode_i;
   logic          a_valid_i, a_ready_o, b_valid_i, b_ready_o;
   logic [3:0]    fpu_ctrl_o;
   logic          fpu_in_valid_o, fpu_en_o;
   logic [5:0]    fpu_flags_i;
   logic          r_valid_o, r_ready_i;
   logic          busy_o, done_o;
   logic [5:0]    flags_o;

   hwpe_vfpu_job_ctrl #(.FP_LAT(FP_LAT), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .clear_i(clear_i),
      .transaction_size_i(transaction_size_i), .operation_i(operation_i),
      .rounding_mode_i(rounding_mode_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .fpu_ctrl_o(fpu_ctrl_o),
      .fpu_in_valid_o(fpu_in_valid_o), .fpu_en_o(fpu_en_o), .fpu_flags_i(fpu_flags_i),
      .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .busy_o(busy_o), .done_o(done_o),
      .flags_o(flags_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int n_fire, n_retire, n_done, done_cyc, first_fire, last_fire;
   int n_busy, n_busy_after, n_lone, n_aready, n_aready_nob;
   int n_stall, n_stall_fire, n_stall_rv, n_ctrl_bad;
   logic busy_post_clear, rv_post_clear;
   logic [3:0] exp_ctrl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0 stream, 1 stall cycles 4..7, 2 b_valid on odd cycles, 3 flags on result 2, 4 clear at cycle 4
   task automatic drive_inputs(input int mode, input int c);
      a_valid_i   = 1'b1;
      b_valid_i   = (mode == 2) ? ((c % 2) == 1) : 1'b1;
      r_ready_i   = (mode == 1 && c >= 4 && c <= 7) ? 1'b0 : 1'b1;
      clear_i     = (mode == 4 && c == 4) ? 1'b1 : 1'b0;
      fpu_flags_i = 6'b000000;
      if (mode == 3 && c == 5) fpu_flags_i = 6'b000001;
      if (mode == 3 && c == 8) fpu_flags_i = 6'b110000;
   endtask

   task automatic sample(input int mode, input int c);
      if (fpu_in_valid_o) begin
         n_fire++;
         last_fire = c;
         if (first_fire < 0) first_fire = c;
      end
      if (r_valid_o && r_ready_i) n_retire++;
      if (done_o) begin
         n_done++;
         if (done_cyc < 0) done_cyc = c;
      end
      if (busy_o) begin
         n_busy++;
         if (done_cyc >= 0) n_busy_after++;
      end
      if (((a_valid_i && a_ready_o) !== (b_valid_i && b_ready_o)) ||
          (fpu_in_valid_o !== (a_valid_i && a_ready_o))) n_lone++;
      if (a_ready_o) n_aready++;
      if (a_ready_o && !b_valid_i) n_aready_nob++;
      if (!fpu_en_o) begin
         n_stall++;
         if (fpu_in_valid_o) n_stall_fire++;
         if (r_valid_o) n_stall_rv++;
      end
      if (fpu_ctrl_o !== exp_ctrl) n_ctrl_bad++;
      if (mode == 4 && c == 5) begin
         busy_post_clear = busy_o;
         rv_post_clear   = r_valid_o;
      end
   endtask

   // Starts at posedge+1, runs until two cycles past done_o or a 30-cycle budget.
   task automatic run_job(input logic [CW-1:0] size, input logic [1:0] op,
                          input logic [1:0] rm, input int mode);
      n_fire = 0; n_retire = 0; n_done = 0; done_cyc = -1; first_fire = -1; last_fire = -1;
      n_busy = 0; n_busy_after = 0; n_lone = 0; n_aready = 0; n_aready_nob = 0;
      n_stall = 0; n_stall_fire = 0; n_stall_rv = 0; n_ctrl_bad = 0;
      busy_post_clear = 1'bx; rv_post_clear = 1'bx;
      exp_ctrl = {op, rm};
      start_i = 1'b1;
      transaction_size_i = size;
      operation_i = op;
      rounding_mode_i = rm;
      drive_inputs(mode, 0);
      for (int c = 1; c <= 30 && (done_cyc < 0 || c <= done_cyc + 2); c++) begin
         @(posedge clk);
         #1;
         start_i = 1'b0;
         transaction_size_i = 16'hFFFF;
         operation_i = ~op;
         rounding_mode_i = ~rm;
         drive_inputs(mode, c);
         #1;
         sample(mode, c);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start_i = 1'b0; clear_i = 1'b0;
      transaction_size_i = '0; operation_i = '0; rounding_mode_i = '0;
      a_valid_i = 1'b1; b_valid_i = 1'b1; r_ready_i = 1'b1; fpu_flags_i = 6'h3F;
      #12;
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_rvalid", r_valid_o, 1'b0);
      check("rst_fpu_en", fpu_en_o, 1'b1);
      check("rst_ctrl", fpu_ctrl_o, 4'b0000);
      check("rst_flags", flags_o, 6'b000000);
      check("rst_aready", a_ready_o, 1'b0);
      check("rst_fire", fpu_in_valid_o, 1'b0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_job(16'd8, 2'b10, 2'b01, 0);
      check("stream_done_cyc", done_cyc, 12);
      check("stream_fires", n_fire, 8);
      check("stream_first_fire", first_fire, 1);
      check("stream_last_fire", last_fire, 8);
      check("stream_retires", n_retire, 8);
      check("stream_done_cnt", n_done, 1);
      check("stream_busy_cycles", n_busy, 11);
      check("stream_busy_after", n_busy_after, 0);
      check("stream_ctrl", fpu_ctrl_o, 4'b1001);
      check("stream_ctrl_stable", n_ctrl_bad, 0);

      run_job(16'd5, 2'b00, 2'b10, 1);
      check("bp_done_cyc", done_cyc, 13);
      check("bp_stall_cycles", n_stall, 4);
      check("bp_fire_in_stall", n_stall_fire, 0);
      check("bp_rvalid_held", n_stall_rv, 4);
      check("bp_fires", n_fire, 5);
      check("bp_retires", n_retire, 5);
      check("bp_done_cnt", n_done, 1);

      run_job(16'd4, 2'b01, 2'b00, 2);
      check("skew_fires", n_fire, 4);
      check("skew_aready", n_aready, 4);
      check("skew_aready_nob", n_aready_nob, 0);
      check("skew_lone", n_lone, 0);
      check("skew_done_cyc", done_cyc, 11);

      run_job(16'd0, 2'b10, 2'b11, 0);
      check("zero_done_cyc", done_cyc, 1);
      check("zero_fires", n_fire, 0);
      check("zero_busy", n_busy, 0);

      run_job(16'd10, 2'b01, 2'b11, 4);
      check("abort_fires", n_fire, 3);
      check("abort_done_cnt", n_done, 0);
      check("abort_busy_next", busy_post_clear, 1'b0);
      check("abort_rvalid_next", rv_post_clear, 1'b0);
      check("abort_ctrl_held", fpu_ctrl_o, 4'b0111);
      check("abort_lone", n_lone, 0);

      run_job(16'd2, 2'b00, 2'b10, 0);
      check("restart_done_cyc", done_cyc, 6);
      check("restart_retires", n_retire, 2);
      check("restart_ctrl", fpu_ctrl_o, 4'b0010);

      run_job(16'd3, 2'b00, 2'b01, 3);
      check("flags_done_cyc", done_cyc, 7);
`ifdef HWPE_VFPU_JOB_CTRL_FLAGS_EN
      check("flags_sticky", flags_o, 6'b000001);
`else
      check("flags_tied", flags_o, 6'b000000);
`endif
      run_job(16'd1, 2'b00, 2'b00, 0);
      check("flags_cleared", flags_o, 6'b000000);
      check("flags_job_done", n_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
